// File: rtl/alu8_sequencer.sv
// Sequences 8-bit add/sub/logic/compare ops over a 4-bit combinational ALU,
// with a carry/borrow fix-up pass on the high nibble when the low nibble needs it.
module alu8_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [2:0] alu_select,
  output logic       alu_in_c,
  output logic [3:0] alu_in_x,
  output logic [3:0] alu_in_y,
  input  logic [3:0] alu_out_s,
  input  logic       alu_out_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_overflow
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LO   = 3'd1;
  localparam logic [2:0] HI   = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0] state_r, state_nxt_s;
  logic [2:0] op_r;
  logic [7:0] a_r, b_r;
  logic [3:0] r_lo_r, r_hi_r;
  logic       c_lo_r, c_hi_r;
  logic       valid_r, carry_r, zero_r, ovf_r;
  logic [7:0] result_r;

  logic        accept_s, is_add_s, is_sub_s, need_fix_s, load_rsp_s;
  logic        fin_carry_s;
  logic [10:0] rsp_pack_s;

  // Builds {result, carry, zero, overflow} from the final 8-bit sum.
  function automatic logic [10:0] pack_rsp(input logic [2:0] op, input logic a7,
                                           input logic b7, input logic [7:0] r,
                                           input logic carry);
    logic       ovf;
    logic       c;
    logic [7:0] res;
    ovf = 1'b0;
    c   = carry;
    res = r;
    case (op)
      3'b000: ovf = (a7 == b7) && (r[7] != a7);
      3'b001: ovf = (a7 != b7) && (r[7] != a7);
      3'b110: begin
        ovf = (a7 != b7) && (r[7] != a7);
        res = {7'b0000000, r[7] ^ ovf};
      end
      3'b111: begin
        ovf = (a7 != b7) && (r[7] != a7);
        res = {7'b0000000, r == 8'h00};
      end
      default: c = 1'b0;
    endcase
    return {res, c, res == 8'h00, ovf};
  endfunction

  assign accept_s = req_valid && req_ready;
  assign is_add_s = (op_r == 3'b000);
  assign is_sub_s = (op_r == 3'b001) || (op_r == 3'b110) || (op_r == 3'b111);

  // Fix-up decision, final carry and response load strobe.
  always_comb begin
    need_fix_s  = 1'b0;
    fin_carry_s = 1'b0;
    if (is_add_s) begin
      need_fix_s = c_lo_r;
    end else if (is_sub_s) begin
      need_fix_s = !c_lo_r;
    end else begin
      need_fix_s = 1'b0;
    end
    if (state_r == FIX) begin
      fin_carry_s = is_add_s ? (c_hi_r | alu_out_c) : (c_hi_r & alu_out_c);
    end else if (is_add_s || is_sub_s) begin
      fin_carry_s = alu_out_c;
    end else begin
      fin_carry_s = 1'b0;
    end
    load_rsp_s = ((state_r == HI) && !need_fix_s) || (state_r == FIX);
    rsp_pack_s = pack_rsp(op_r, a_r[7], b_r[7], {alu_out_s, r_lo_r}, fin_carry_s);
  end

  // ALU pin drive decoded from the current pass.
  always_comb begin
    alu_select = 3'b000;
    alu_in_c   = 1'b0;
    alu_in_x   = 4'h0;
    alu_in_y   = 4'h0;
    case (state_r)
      LO: begin
        alu_select = is_sub_s ? 3'b001 : op_r;
        alu_in_c   = is_sub_s;
        alu_in_x   = a_r[3:0];
        alu_in_y   = b_r[3:0];
      end
      HI: begin
        alu_select = is_sub_s ? 3'b001 : op_r;
        alu_in_c   = is_sub_s;
        alu_in_x   = a_r[7:4];
        alu_in_y   = b_r[7:4];
      end
      FIX: begin
        alu_select = is_sub_s ? 3'b001 : 3'b000;
        alu_in_c   = is_sub_s;
        alu_in_x   = r_hi_r;
        alu_in_y   = 4'h1;
      end
      default: begin
        alu_select = 3'b000;
        alu_in_c   = 1'b0;
        alu_in_x   = 4'h0;
        alu_in_y   = 4'h0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? LO : IDLE;
      LO:      state_nxt_s = HI;
      HI:      state_nxt_s = need_fix_s ? FIX : DONE;
      FIX:     state_nxt_s = DONE;
      DONE:    state_nxt_s = rsp_ready ? IDLE : DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, request latch and per-pass captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      op_r    <= 3'b000;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      r_lo_r  <= 4'h0;
      r_hi_r  <= 4'h0;
      c_lo_r  <= 1'b0;
      c_hi_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        op_r <= req_op;
        a_r  <= req_a;
        b_r  <= req_b;
      end else if (state_r == LO) begin
        r_lo_r <= alu_out_s;
        c_lo_r <= alu_out_c;
      end else if (state_r == HI || state_r == FIX) begin
        r_hi_r <= alu_out_s;
        c_hi_r <= (state_r == HI) ? alu_out_c : c_hi_r;
      end else begin
        r_lo_r <= r_lo_r;
      end
    end
  end

  // Response registers, loaded together with rsp_valid and held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      result_r <= 8'h00;
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (load_rsp_s) begin
      valid_r                                <= 1'b1;
      {result_r, carry_r, zero_r, ovf_r}     <= rsp_pack_s;
    end else if (valid_r && rsp_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign req_ready    = (state_r == IDLE) && !rst;
  assign rsp_valid    = valid_r;
  assign rsp_result   = result_r;
  assign rsp_carry    = carry_r;
  assign rsp_zero     = zero_r;
  assign rsp_overflow = ovf_r;

endmodule

// File: tb/tb_alu8_sequencer.sv
// Directed bench for alu8_sequencer with a behavioural 4-bit ALU model.
module tb_alu8_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [2:0] req_op = 3'b000;
  logic [7:0] req_a = 8'h00, req_b = 8'h00;
  logic [2:0] alu_select;
  logic       alu_in_c;
  logic [3:0] alu_in_x, alu_in_y;
  logic [3:0] alu_out_s;
  logic       alu_out_c;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_overflow;
  int checks = 0;
  int failures = 0;

  alu8_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_select(alu_select),
    .alu_in_c(alu_in_c), .alu_in_x(alu_in_x), .alu_in_y(alu_in_y),
    .alu_out_s(alu_out_s), .alu_out_c(alu_out_c), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  // Reference 4-bit ALU: add/sub produce carry, logic ops do not.
  always_comb begin
    logic [4:0] t;
    t = 5'd0;
    case (alu_select)
      3'b000:  t = {1'b0, alu_in_x} + {1'b0, alu_in_y} + {4'd0, alu_in_c};
      3'b001:  t = {1'b0, alu_in_x} + {1'b0, ~alu_in_y} + {4'd0, alu_in_c};
      3'b010:  t = {1'b0, ~alu_in_x};
      3'b011:  t = {1'b0, alu_in_x & alu_in_y};
      3'b100:  t = {1'b0, alu_in_x | alu_in_y};
      3'b101:  t = {1'b0, alu_in_x ^ alu_in_y};
      default: t = {1'b0, alu_in_x} + {1'b0, ~alu_in_y} + {4'd0, alu_in_c};
    endcase
    alu_out_s = t[3:0];
    alu_out_c = t[4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, waits for the response, checks it and acknowledges.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res, input logic c,
                       input logic z, input logic v, input int lat);
    int n;
    @(negedge clk);
    check({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_a = ~a; req_b = ~b;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, rsp_result, res);
    check({tag, " flags"}, {rsp_carry, rsp_zero, rsp_overflow}, {c, z, v});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, " released"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int n;
    #2;
    check("reset outputs", {req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_overflow}, 0);
    check("reset alu drive", {alu_select, alu_in_c, alu_in_x, alu_in_y}, 0);
    @(negedge clk); rst = 1'b0;
    #1 check("ready after release", req_ready, 1);

    do_op("add 3c+05", 3'b000, 8'h3C, 8'h05, 8'h41, 0, 0, 0, 4);
    do_op("add 7f+01", 3'b000, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 4);
    do_op("add ff+01", 3'b000, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 4);
    do_op("add 12+34", 3'b000, 8'h12, 8'h34, 8'h46, 0, 0, 0, 3);
    do_op("sub 10-01", 3'b001, 8'h10, 8'h01, 8'h0F, 1, 0, 0, 4);
    do_op("sub 00-01", 3'b001, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 4);
    do_op("sub 80-01", 3'b001, 8'h80, 8'h01, 8'h7F, 1, 0, 1, 4);
    do_op("not",       3'b010, 8'hA5, 8'h3C, 8'h5A, 0, 0, 0, 3);
    do_op("and",       3'b011, 8'hA5, 8'h3C, 8'h24, 0, 0, 0, 3);
    do_op("or",        3'b100, 8'hA5, 8'h3C, 8'hBD, 0, 0, 0, 3);
    do_op("xor",       3'b101, 8'hA5, 8'h3C, 8'h99, 0, 0, 0, 3);
    do_op("eq a5 a5",  3'b111, 8'hA5, 8'hA5, 8'h01, 1, 0, 0, 3);
    do_op("eq a5 a4",  3'b111, 8'hA5, 8'hA4, 8'h00, 1, 1, 0, 3);
    do_op("lt 80 01",  3'b110, 8'h80, 8'h01, 8'h01, 1, 0, 1, 4);
    do_op("lt 01 80",  3'b110, 8'h01, 8'h80, 8'h00, 0, 1, 1, 3);

    // Backpressure: response held, stray request ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b000; req_a = 8'h12; req_b = 8'h34;
    @(posedge clk); #1;
    req_op = 3'b101; req_a = 8'hFF; req_b = 8'h0F;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    check("bp latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold", {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_overflow, req_ready}, {1'b1, 8'h46, 4'b0000});
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp no stray op", {rsp_valid, req_ready}, 2'b01);
    end

    // Reset during HI pass aborts the op.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b000; req_a = 8'h3C; req_b = 8'h05;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hi drive", {alu_select, alu_in_x, alu_in_y}, {3'b000, 4'h3, 4'h0});
    rst = 1'b1;
    #1 check("mid reset outputs", {req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_overflow}, 0);
    check("mid reset alu", {alu_select, alu_in_c, alu_in_x, alu_in_y}, 0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("aborted no rsp", n, 0);
    do_op("after reset", 3'b000, 8'h3C, 8'h05, 8'h41, 0, 0, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
